// File: rtl/dma_source_scheduler.sv
// ============================================================================
// Module      : dma_source_scheduler
// Description : Shares one TileLink-UL master port among NumReq DMA requesters.
//               Requests are granted round-robin into a single registered A
//               stage. Each grant takes the lowest free source ID from a pool
//               of 2**SourceWidth IDs. D beats are routed back to the owning
//               requester by source ID, and the ID is returned to the pool on
//               the D handshake.
// Ports       : clk_i/rst_i             clock, asynchronous active-high reset
//               req_*_i / req_ready_o   per-requester request channel
//               rsp_*_o / rsp_ready_i   per-requester response (data shared)
//               a_*                     TileLink A channel (registered)
//               d_*                     TileLink D channel (routed comb.)
//               idle_o                  no source outstanding and A stage empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_source_scheduler #(
    parameter int NumReq      = 4,
    parameter int SourceWidth = 2,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_error_o,
    output logic                          a_valid_o,
    input  logic                          a_ready_i,
    output logic [2:0]                    a_opcode_o,
    output logic [SourceWidth-1:0]        a_source_o,
    output logic [AddrWidth-1:0]          a_address_o,
    output logic [DataWidth-1:0]          a_data_o,
    input  logic                          d_valid_i,
    output logic                          d_ready_o,
    input  logic [SourceWidth-1:0]        d_source_i,
    input  logic [DataWidth-1:0]          d_data_i,
    input  logic                          d_denied_i,
    output logic                          idle_o
);

    localparam int c_NSRC = 2 ** SourceWidth;
    localparam int c_OW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int c_OFF  = $clog2(DataWidth / 8);

    localparam logic [2:0]           c_OP_PUT_FULL = 3'd0;
    localparam logic [2:0]           c_OP_GET      = 3'd4;
    localparam logic [c_OW-1:0]      c_LAST_REQ    = c_OW'(NumReq - 1);
    // Clears the byte-offset bits: every access is one full-width beat.
    localparam logic [AddrWidth-1:0] c_ADDR_MASK   =
        ~(AddrWidth'((64'd1 << c_OFF) - 64'd1));

    // Source pool and ownership
    logic [c_NSRC-1:0] r_free;
    logic [c_OW-1:0]   r_owner [c_NSRC];
    logic [c_OW-1:0]   r_rr;

    // Registered A stage
    logic                   r_a_valid;
    logic [2:0]             r_a_opcode;
    logic [SourceWidth-1:0] r_a_source;
    logic [AddrWidth-1:0]   r_a_address;
    logic [DataWidth-1:0]   r_a_data;

    logic                   w_found;
    logic [c_OW-1:0]        w_grantee;
    logic                   w_any_free;
    logic [SourceWidth-1:0] w_src;
    logic                   w_a_slot;
    logic                   w_grant;
    logic                   w_d_alloc;
    logic [c_OW-1:0]        w_d_owner;
    logic                   w_d_hs;

    // Round-robin search starting at r_rr.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_found   = 1'b0;
        w_grantee = '0;
        for (int k = 0; k < NumReq; k++) begin
            v_idx = int'(r_rr) + k;
            if (v_idx >= NumReq) begin
                v_idx = v_idx - NumReq;
            end
            if (!w_found && req_valid_i[v_idx]) begin
                w_found   = 1'b1;
                w_grantee = c_OW'(v_idx);
            end
        end
    end

    // Lowest-index free source; descending scan so the lowest hit wins.
    always_comb begin
        w_any_free = |r_free;
        w_src      = '0;
        for (int s = c_NSRC - 1; s >= 0; s--) begin
            if (r_free[s]) begin
                w_src = SourceWidth'(s);
            end
        end
    end

    // The grant decision uses the registered free bitmap only, so a source
    // released by this cycle's D handshake is not reused until next cycle.
    assign w_a_slot    = !r_a_valid || a_ready_i;
    assign w_grant     = w_found && w_any_free && w_a_slot && !rst_i;
    assign req_ready_o = w_grant ? (NumReq'(1) << w_grantee) : '0;

    // D routing. Unallocated sources (stray or pre-reset beats) are
    // swallowed: always ready, never presented to any requester.
    assign w_d_alloc   = !r_free[d_source_i];
    assign w_d_owner   = r_owner[d_source_i];
    assign d_ready_o   = w_d_alloc ? rsp_ready_i[w_d_owner] : 1'b1;
    assign rsp_valid_o = (d_valid_i && w_d_alloc) ? (NumReq'(1) << w_d_owner) : '0;
    assign rsp_rdata_o = d_data_i;
    assign rsp_error_o = d_denied_i;
    assign w_d_hs      = d_valid_i && d_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_free      <= '1;
            r_rr        <= '0;
            r_a_valid   <= 1'b0;
            r_a_opcode  <= '0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_data    <= '0;
            for (int s = 0; s < c_NSRC; s++) begin
                r_owner[s] <= '0;
            end
        end else begin
            // Set before the grant clear: if a stray beat names the very
            // source being allocated, the allocation must win.
            if (w_d_hs) begin
                r_free[d_source_i] <= 1'b1;
            end
            if (w_grant) begin
                r_free[w_src]  <= 1'b0;
                r_owner[w_src] <= w_grantee;
                r_rr           <= (w_grantee == c_LAST_REQ) ? '0 : w_grantee + 1'b1;
                r_a_valid      <= 1'b1;
                r_a_opcode     <= req_write_i[w_grantee] ? c_OP_PUT_FULL : c_OP_GET;
                r_a_source     <= w_src;
                r_a_address    <= req_addr_i[w_grantee*AddrWidth +: AddrWidth] & c_ADDR_MASK;
                r_a_data       <= req_wdata_i[w_grantee*DataWidth +: DataWidth];
            end else if (a_ready_i) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    assign a_valid_o   = r_a_valid;
    assign a_opcode_o  = r_a_opcode;
    assign a_source_o  = r_a_source;
    assign a_address_o = r_a_address;
    assign a_data_o    = r_a_data;
    assign idle_o      = (&r_free) && !r_a_valid;

endmodule

`default_nettype wire

// File: tb/tb_dma_source_scheduler.sv
// ============================================================================
// Module      : tb_dma_source_scheduler
// Description : Directed self-checking bench for dma_source_scheduler.
//               Inputs change on the falling edge; outputs are checked 1 ns
//               later, away from the rising (active) edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_source_scheduler;

    localparam int NR = 4;
    localparam int SW = 2;
    localparam int AW = 56;
    localparam int DW = 128;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     req_write_i = '0;
    logic [NR*AW-1:0]  req_addr_i  = '0;
    logic [NR*DW-1:0]  req_wdata_i = '0;
    logic [NR-1:0]     rsp_valid_o;
    logic [NR-1:0]     rsp_ready_i = '0;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_error_o;
    logic              a_valid_o;
    logic              a_ready_i = 1'b0;
    logic [2:0]        a_opcode_o;
    logic [SW-1:0]     a_source_o;
    logic [AW-1:0]     a_address_o;
    logic [DW-1:0]     a_data_o;
    logic              d_valid_i = 1'b0;
    logic              d_ready_o;
    logic [SW-1:0]     d_source_i = '0;
    logic [DW-1:0]     d_data_i = '0;
    logic              d_denied_i = 1'b0;
    logic              idle_o;

    int n_cmp = 0;
    int n_err = 0;

    dma_source_scheduler #(
        .NumReq(NR), .SourceWidth(SW), .AddrWidth(AW), .DataWidth(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
        .a_opcode_o(a_opcode_o), .a_source_o(a_source_o),
        .a_address_o(a_address_o), .a_data_o(a_data_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o),
        .d_source_i(d_source_i), .d_data_i(d_data_i),
        .d_denied_i(d_denied_i), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_write_i[i]          = w;
        req_addr_i[i*AW +: AW]  = a;
        req_wdata_i[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_valid_i = '0; d_valid_i = 1'b0; a_ready_i = 1'b0; rsp_ready_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        req_valid_i = 4'b1111;
        @(negedge clk_i); #1;
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_a_valid: got %b want 0", a_valid_o); end
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle_o); end
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready_o); end
        n_cmp++; if (rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid_o); end
        req_valid_i = '0;
        rst_i = 1'b0;
        #1;
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rst_idle_after: got %b want 1", idle_o); end
    endtask

    task automatic test_single_read();
        @(negedge clk_i);
        set_req(0, 1'b0, 56'h0000_0000_4000_0013, '0);
        req_valid_i = 4'b0001; a_ready_i = 1'b1; rsp_ready_i = 4'b1111;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL rd_grant: got %b want 0001", req_ready_o); end
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_a_not_yet: got %b want 0", a_valid_o); end
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        n_cmp++; if (a_valid_o !== 1'b1) begin n_err++; $display("FAIL rd_a_valid: got %b want 1", a_valid_o); end
        n_cmp++; if (a_opcode_o !== 3'd4) begin n_err++; $display("FAIL rd_opcode: got %0d want 4", a_opcode_o); end
        n_cmp++; if (a_source_o !== 2'd0) begin n_err++; $display("FAIL rd_source: got %0d want 0", a_source_o); end
        n_cmp++; if (a_address_o !== 56'h0000_0000_4000_0010) begin n_err++; $display("FAIL rd_addr: got %h want 40000010", a_address_o); end
        n_cmp++; if (idle_o !== 1'b0) begin n_err++; $display("FAIL rd_busy: got %b want 0", idle_o); end
        @(negedge clk_i);
        d_valid_i = 1'b1; d_source_i = 2'd0; d_data_i = {4{32'hDEAD_BEEF}};
        #1;
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_a_drained: got %b want 0", a_valid_o); end
        n_cmp++; if (rsp_valid_o !== 4'b0001) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 0001", rsp_valid_o); end
        n_cmp++; if (d_ready_o !== 1'b1) begin n_err++; $display("FAIL rd_d_ready: got %b want 1", d_ready_o); end
        n_cmp++; if (rsp_rdata_o !== {4{32'hDEAD_BEEF}}) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef x4", rsp_rdata_o); end
        @(negedge clk_i);
        d_valid_i = 1'b0;
        #1;
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rd_idle_end: got %b want 1", idle_o); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_op;
        logic [3:0] wr_pat;
        logic [AW-1:0] exp_addr;
        do_reset();
        wr_pat = 4'b0101;
        for (int i = 0; i < NR; i++) begin
            set_req(i, wr_pat[i], AW'(32'h1000 * (i + 1) + 32'h3F), {4{32'hA000_0000 + i}});
        end
        @(negedge clk_i);
        req_valid_i = 4'b1111; a_ready_i = 1'b1;
        for (int i = 0; i < NR; i++) begin
            #1;
            n_cmp++; if (req_ready_o !== (4'b0001 << i)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready_o, 4'b0001 << i); end
            @(negedge clk_i);
            exp_op   = wr_pat[i] ? 3'd0 : 3'd4;
            exp_addr = AW'(32'h1000 * (i + 1) + 32'h30);
            n_cmp++; if (a_source_o !== SW'(i)) begin n_err++; $display("FAIL rr_source%0d: got %0d want %0d", i, a_source_o, i); end
            n_cmp++; if (a_opcode_o !== exp_op) begin n_err++; $display("FAIL rr_opcode%0d: got %0d want %0d", i, a_opcode_o, exp_op); end
            n_cmp++; if (a_address_o !== exp_addr) begin n_err++; $display("FAIL rr_addr%0d: got %h want %h", i, a_address_o, exp_addr); end
            if (wr_pat[i]) begin
                n_cmp++; if (a_data_o !== {4{32'hA000_0000 + i}}) begin n_err++; $display("FAIL rr_data%0d: got %h", i, a_data_o); end
            end
        end
        #1;
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL rr_pool_full: got %b want 0000", req_ready_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL rr_pool_full2: got %b want 0000", req_ready_o); end
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL rr_a_drained: got %b want 0", a_valid_o); end
    endtask

    task automatic test_pool_free();
        @(negedge clk_i);
        d_valid_i = 1'b1; d_source_i = 2'd2; rsp_ready_i = 4'b1111;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b0100) begin n_err++; $display("FAIL pf_rsp_valid: got %b want 0100", rsp_valid_o); end
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL pf_no_same_cycle: got %b want 0000", req_ready_o); end
        @(negedge clk_i);
        d_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL pf_regrant: got %b want 0001", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        n_cmp++; if (a_source_o !== 2'd2) begin n_err++; $display("FAIL pf_source: got %0d want 2", a_source_o); end
    endtask

    task automatic test_backpressure();
        @(negedge clk_i);
        d_valid_i = 1'b1; d_source_i = 2'd0;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b0001) begin n_err++; $display("FAIL bp_free0: got %b want 0001", rsp_valid_o); end
        @(negedge clk_i);
        d_source_i = 2'd1;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b0010) begin n_err++; $display("FAIL bp_free1: got %b want 0010", rsp_valid_o); end
        @(negedge clk_i);
        d_valid_i = 1'b0; a_ready_i = 1'b0;
        set_req(1, 1'b1, 56'h0000_0000_2222_0005, {4{32'h5A5A_1234}});
        set_req(2, 1'b0, 56'h0000_0000_3333_00F0, '0);
        req_valid_i = 4'b0010;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0010) begin n_err++; $display("FAIL bp_grant: got %b want 0010", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL bp_nogrant%0d: got %b want 0000", c, req_ready_o); end
            n_cmp++; if (a_valid_o !== 1'b1 || a_source_o !== 2'd0 || a_opcode_o !== 3'd0 ||
                         a_address_o !== 56'h0000_0000_2222_0000 || a_data_o !== {4{32'h5A5A_1234}}) begin
                n_err++; $display("FAIL bp_stable%0d: got v=%b src=%0d op=%0d addr=%h", c, a_valid_o, a_source_o, a_opcode_o, a_address_o);
            end
            @(negedge clk_i);
        end
        a_ready_i = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0100) begin n_err++; $display("FAIL bp_resume: got %b want 0100", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = '0;
        #1;
        n_cmp++; if (a_source_o !== 2'd1 || a_address_o !== 56'h0000_0000_3333_00F0 || a_opcode_o !== 3'd4) begin
            n_err++; $display("FAIL bp_second: got src=%0d addr=%h op=%0d want 1 333300f0 4", a_source_o, a_address_o, a_opcode_o);
        end
        #1;
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL bp_single: got %b want 0000", req_ready_o); end
    endtask

    task automatic test_out_of_order();
        @(negedge clk_i);
        d_valid_i = 1'b1; d_source_i = 2'd3; d_data_i = {4{32'h0BAD_F00D}};
        d_denied_i = 1'b0; rsp_ready_i = 4'b0111;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b1000) begin n_err++; $display("FAIL ooo_rsp3: got %b want 1000", rsp_valid_o); end
        n_cmp++; if (d_ready_o !== 1'b0) begin n_err++; $display("FAIL ooo_stall3: got %b want 0", d_ready_o); end
        @(negedge clk_i);
        rsp_ready_i = 4'b1000;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b1000) begin n_err++; $display("FAIL ooo_held3: got %b want 1000", rsp_valid_o); end
        n_cmp++; if (d_ready_o !== 1'b1) begin n_err++; $display("FAIL ooo_ready3: got %b want 1", d_ready_o); end
        @(negedge clk_i);
        d_source_i = 2'd1; d_denied_i = 1'b1; rsp_ready_i = 4'b0100;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b0100) begin n_err++; $display("FAIL ooo_rsp1: got %b want 0100", rsp_valid_o); end
        n_cmp++; if (d_ready_o !== 1'b1) begin n_err++; $display("FAIL ooo_ready1: got %b want 1", d_ready_o); end
        n_cmp++; if (rsp_error_o !== 1'b1) begin n_err++; $display("FAIL ooo_denied: got %b want 1", rsp_error_o); end
        @(negedge clk_i);
        d_source_i = 2'd3; d_denied_i = 1'b0; rsp_ready_i = 4'b0000;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b0000 || d_ready_o !== 1'b1) begin
            n_err++; $display("FAIL ooo_freed3: got rsp=%b rdy=%b want 0000 1", rsp_valid_o, d_ready_o);
        end
        d_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        a_ready_i = 1'b0;
        req_valid_i = 4'b0001;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL rm_grant: got %b want 0001", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 4'b1111;
        #1;
        n_cmp++; if (a_valid_o !== 1'b1 || idle_o !== 1'b0 || a_source_o !== 2'd1) begin
            n_err++; $display("FAIL rm_busy: got v=%b idle=%b src=%0d want 1 0 1", a_valid_o, idle_o, a_source_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rm_idle: got %b want 1", idle_o); end
        n_cmp++; if (a_valid_o !== 1'b0) begin n_err++; $display("FAIL rm_a_valid: got %b want 0", a_valid_o); end
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL rm_req_ready: got %b want 0000", req_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b0; req_valid_i = '0;
        d_valid_i = 1'b1; d_source_i = 2'd2; rsp_ready_i = 4'b0000;
        #1;
        n_cmp++; if (rsp_valid_o !== 4'b0000) begin n_err++; $display("FAIL rm_stray_rsp: got %b want 0000", rsp_valid_o); end
        n_cmp++; if (d_ready_o !== 1'b1) begin n_err++; $display("FAIL rm_stray_ready: got %b want 1", d_ready_o); end
        @(negedge clk_i);
        d_valid_i = 1'b0;
        #1;
        n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rm_idle_end: got %b want 1", idle_o); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_pool_free();
        test_backpressure();
        test_out_of_order();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_source_scheduler.md
DMA_SOURCE_SCHEDULER -- requirements
Module: dma_source_scheduler

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of DMA requesters sharing the port.
REQ-002 SHALL have parameter SourceWidth, default 2, TileLink source width; pool size = 2**SourceWidth.
REQ-003 SHALL have parameter AddrWidth, default 56, address width.
REQ-004 SHALL have parameter DataWidth, default 128, beat width in bits.
REQ-005 SHALL have port clk_i  in  1  clock; single clock domain.
REQ-006 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port req_valid_i  in  NumReq  per-requester request valid.
REQ-008 SHALL have port req_ready_o  out  NumReq  per-requester grant (accept).
REQ-009 SHALL have port req_write_i  in  NumReq  1=write (PutFullData), 0=read (Get).
REQ-010 SHALL have port req_addr_i  in  NumReq*AddrWidth  per-requester address.
REQ-011 SHALL have port req_wdata_i  in  NumReq*DataWidth  per-requester write data.
REQ-012 SHALL have port rsp_valid_o  out  NumReq  per-requester response valid.
REQ-013 SHALL have port rsp_ready_i  in  NumReq  per-requester response ready.
REQ-014 SHALL have port rsp_rdata_o  out  DataWidth  response data, shared by all requesters.
REQ-015 SHALL have port rsp_error_o  out  1  response error (d_denied), shared.
REQ-016 SHALL have port a_valid_o  out  1  TileLink A valid.
REQ-017 SHALL have port a_ready_i  in  1  TileLink A ready.
REQ-018 SHALL have port a_opcode_o  out  3  A opcode.
REQ-019 SHALL have port a_source_o  out  SourceWidth  A source ID.
REQ-020 SHALL have port a_address_o  out  AddrWidth  A address.
REQ-021 SHALL have port a_data_o  out  DataWidth  A data.
REQ-022 SHALL have port d_valid_i  in  1  TileLink D valid.
REQ-023 SHALL have port d_ready_o  out  1  TileLink D ready.
REQ-024 SHALL have port d_source_i  in  SourceWidth  D source ID.
REQ-025 SHALL have port d_data_i  in  DataWidth  D data.
REQ-026 SHALL have port d_denied_i  in  1  D denied.
REQ-027 SHALL have port idle_o  out  1  no outstanding source and A stage empty.

Function
REQ-028 SHALL hold a one-entry registered A stage; a_* are driven only from this register.
REQ-029 SHALL keep A stage contents stable while a_valid_o=1 and a_ready_i=0.
REQ-030 SHALL grant at most one requester per cycle, only when a source is free (registered free bitmap) and the A stage is empty or draining (a_ready_i=1) that cycle.
REQ-031 SHALL pick the grantee round-robin starting at pointer rr; after a grant, rr = grantee+1 mod NumReq; rr is unchanged without a grant.
REQ-032 SHALL allocate the lowest-index free source, clear its free bit and record grantee as owner, on the grant cycle; a_valid_o rises the next cycle.
REQ-033 SHALL drive a_opcode_o=0 for writes and 4 for reads, a_address_o = req_addr with low log2(DataWidth/8) bits forced to 0, and implicit size log2(DataWidth/8) with full mask.
REQ-034 SHALL route D combinationally: rsp_valid_o[owner[d_source_i]] = d_valid_i; d_ready_o = rsp_ready_i[owner]; rsp_rdata_o=d_data_i; rsp_error_o=d_denied_i.
REQ-035 SHALL set the free bit of d_source_i on a D handshake; a freed source SHALL NOT be reallocated in the same cycle.
REQ-036 SHALL accept and discard a D beat whose source is not allocated: d_ready_o=1, no rsp_valid_o asserted.
REQ-037 SHALL hold all req_ready_o=0 while every source is allocated (pool full).
REQ-038 SHALL drive idle_o=1 iff all sources are free and a_valid_o=0.

Reset
REQ-039 SHALL on rst_i=1, asynchronously: a_valid_o=0, all sources free, owners 0, rr=0, req_ready_o=0, idle_o=1.
REQ-040 SHALL forget in-flight sources on reset; late D beats after reset are discarded per REQ-036.

Verification
REQ-041 Single read: req_valid_i=0001, write=0, addr=0x4000_0013 -> A: opcode 4, source 0, address 0x4000_0010 next cycle; D source 0 -> rsp_valid_o=0001.
REQ-042 Round-robin: req_valid_i=1111 held, a_ready_i=1, no D -> grants 0,1,2,3 on consecutive cycles, sources 0..3, then req_ready_o=0000.
REQ-043 Pool full then free: 4 outstanding; D handshake source 2 -> next grant gets source 2, not earlier than the cycle after the D handshake.
REQ-044 Backpressure: a_ready_i=0 for 5 cycles -> a_* stable, no further grant; single grant resumes after a_ready_i=1.
REQ-045 Out-of-order D: sources 3,1 returned with rsp_ready_i gating owner -> d_ready_o follows owner's ready; denied beat -> rsp_error_o=1.
REQ-046 Reset mid-operation: assert rst_i with 3 outstanding -> idle_o=1 immediately; subsequent stray D discarded, no rsp_valid_o.
